dp_demod: RTL



---
 rtl/dp_demod.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dp_demod.sv
// Non-coherent AM/FM demodulator: rectifier or delay-and-multiply detector followed by a 2^-K IIR low-pass.
// Optional DC-blocking output stage enabled by defining DP_DEMOD_DC_BLOCK_EN.
module dp_demod #(
  parameter int W = 16,
  parameter int K = 4,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         ic_rst_n,
  input  logic [W-1:0] id_data,
  input  logic         ic_val_data,
  input  logic         ic_fm_am,
  input  logic         ic_clr,
  output logic [W-1:0] od_data,
  output logic         oc_val_data
);

  localparam int AW = W + K + 1;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(D + 1);
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [D-1:0][W-1:0]   dl_q, dl_d;
  logic                  pend_q, pend_d;
  logic signed [W-1:0]   e_q, e_d;
  logic                  ve_q, ve_d;
  logic                  rse_q, rse_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  va_q, va_d;
  logic [W-1:0]          od_q, od_d;
  logic                  val_q, val_d;

  logic                  first;
  logic signed [W-1:0]   x, x_old, am_e, fm_e, y;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc_base;

`ifdef DP_DEMOD_DC_BLOCK_EN
  localparam int DW = W + K + 5;
  localparam int DS = K + 4;
  localparam int EW = W + 2;

  logic                  rsa_q, rsa_d;
  logic signed [DW-1:0]  dc_q, dc_d;
  logic signed [DW-1:0]  dc_base, dcs;
  logic signed [EW-1:0]  diff;
`endif

  // Both detectors are always evaluated; the FSM picks one per accepted sample.
  always_comb begin
    x     = $signed(id_data);
    x_old = $signed(dl_q[D-1]);
    prod  = PW'(x) * PW'(x_old);
    am_e  = (x == SMIN) ? SMAX : (x[W-1] ? -x : x);
    fm_e  = (x == SMIN && x_old == SMIN) ? SMAX : W'(prod >>> (W - 1));
  end

  // Front end: mode tracking, delay-line fill and detector register. A mode change
  // does not touch acc directly; the first new-mode sample carries a restart flag instead,
  // so the old-mode samples still in flight finish on the old accumulator.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    pend_d  = pend_q;
    e_d     = e_q;
    ve_d    = 1'b0;
    rse_d   = rse_q;
    first   = 1'b0;
    if (ic_clr) begin
      state_d = IDLE;
      mode_d  = 1'b0;
      cnt_d   = '0;
      dl_d    = '0;
      pend_d  = 1'b0;
      e_d     = '0;
      rse_d   = 1'b0;
    end else if (ic_val_data) begin
      first   = (state_q == IDLE) || (ic_fm_am != mode_q);
      dl_d[0] = id_data;
      for (int i = 1; i < D; i++) begin
        dl_d[i] = first ? '0 : dl_q[i-1];
      end
      if (first) begin
        mode_d = ic_fm_am;
        pend_d = 1'b1;
        if (ic_fm_am) begin
          cnt_d   = CW'(1);
          state_d = (D == 1) ? RUN : FILL;
        end else begin
          state_d = RUN;
          ve_d    = 1'b1;
          e_d     = am_e;
          rse_d   = 1'b1;
          pend_d  = 1'b0;
        end
      end else if (state_q == FILL) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(D)) begin
          state_d = RUN;
        end
      end else begin
        ve_d   = 1'b1;
        e_d    = mode_q ? fm_e : am_e;
        rse_d  = pend_q;
        pend_d = 1'b0;
      end
    end
  end

  // Back end: IIR low-pass update, then the output register.
  always_comb begin
    acc_d    = acc_q;
    va_d     = 1'b0;
    od_d     = od_q;
    val_d    = 1'b0;
    acc_base = rse_q ? '0 : acc_q;
    y        = W'(acc_q >>> K);
`ifdef DP_DEMOD_DC_BLOCK_EN
    rsa_d    = rsa_q;
    dc_d     = dc_q;
    dc_base  = rsa_q ? '0 : dc_q;
    dcs      = dc_base >>> DS;
    diff     = EW'(y) - EW'(dcs);
`endif
    if (ic_clr) begin
      acc_d = '0;
      od_d  = '0;
`ifdef DP_DEMOD_DC_BLOCK_EN
      rsa_d = 1'b0;
      dc_d  = '0;
`endif
    end else begin
      if (ve_q) begin
        acc_d = acc_base + AW'(e_q) - (acc_base >>> K);
        va_d  = 1'b1;
`ifdef DP_DEMOD_DC_BLOCK_EN
        rsa_d = rse_q;
`endif
      end
      if (va_q) begin
        val_d = 1'b1;
`ifdef DP_DEMOD_DC_BLOCK_EN
        dc_d  = dc_base + DW'(y) - dcs;
        if (diff > EW'(SMAX)) begin
          od_d = SMAX;
        end else if (diff < EW'(SMIN)) begin
          od_d = SMIN;
        end else begin
          od_d = W'(diff);
        end
`else
        od_d  = y;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      dl_q    <= '0;
      pend_q  <= 1'b0;
      e_q     <= '0;
      ve_q    <= 1'b0;
      rse_q   <= 1'b0;
      acc_q   <= '0;
      va_q    <= 1'b0;
      od_q    <= '0;
      val_q   <= 1'b0;
`ifdef DP_DEMOD_DC_BLOCK_EN
      rsa_q   <= 1'b0;
      dc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      pend_q  <= pend_d;
      e_q     <= e_d;
      ve_q    <= ve_d;
      rse_q   <= rse_d;
      acc_q   <= acc_d;
      va_q    <= va_d;
      od_q    <= od_d;
      val_q   <= val_d;
`ifdef DP_DEMOD_DC_BLOCK_EN
      rsa_q   <= rsa_d;
      dc_q    <= dc_d;
`endif
    end
  end

  assign od_data     = od_q;
  assign oc_val_data = val_q;

endmodule
